jk_cnt_ctrl: RTL and testbench

JK_CNT_CTRL -- requirements
Module: jk_cnt_ctrl

---
 rtl/jk_cnt_ctrl.sv | 95 +++++++++
 tb/tb_jk_cnt_ctrl.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/jk_cnt_ctrl.sv
// jk_cnt_ctrl: FSM driving a JK flip-flop bank as a loadable modulo up/down counter
module jk_cnt_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             start,
  input  logic             stop,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  input  logic             dir,
  input  logic [WIDTH-1:0] mod_val,
  input  logic             oneshot,
  input  logic             oe,
  input  logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] j,
  output logic [WIDTH-1:0] k,
  output logic [WIDTH-1:0] dout,
  output logic             busy,
  output logic             tc
);
  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;
  state_t state_q, state_d;
  logic dir_q, dir_d, os_q, os_d, tc_q, tc_d;
  logic [WIDTH-1:0] mod_q, mod_d, din_q, din_d, mm1, t_up, t_dn;
  logic wrap_up, wrap_dn, wrap;
  // a latched modulus of 0 underflows to all ones, i.e. a modulus of 2^WIDTH
  assign mm1 = mod_q - WIDTH'(1);
  assign wrap_up = (q == mm1) || (&q);
  assign wrap_dn = ~|q;
  assign wrap = (state_q == RUN) && (dir_q ? wrap_up : wrap_dn);
  for (genvar i = 0; i < WIDTH; i++) begin : g_t
    localparam logic [WIDTH-1:0] LO = (WIDTH'(1) << i) - WIDTH'(1);
    assign t_up[i] = (q & LO) == LO;
    assign t_dn[i] = (q & LO) == '0;
  end
  assign busy = state_q == RUN;
  assign dout = oe ? q : '0;
  assign tc = tc_q;
  always_comb begin
    j = '0;
    k = '0;
    if (clr)
      k = '1;
    else if (state_q == LOAD) begin
      j = din_q;
      k = ~din_q;
    end else if (state_q == RUN && dir_q) begin
      j = wrap_up ? '0 : t_up;
      k = wrap_up ? '1 : t_up;
    end else if (state_q == RUN) begin
      j = wrap_dn ? mm1 : t_dn;
      k = wrap_dn ? ~mm1 : t_dn;
    end
  end
  always_comb begin
    state_d = state_q;
    dir_d = dir_q;
    mod_d = mod_q;
    os_d = os_q;
    din_d = din_q;
    tc_d = wrap;
    if (load) begin
      din_d = din;
      state_d = LOAD;
    end else if (stop)
      state_d = (state_q == DONE) ? DONE : IDLE;
    else if (start && (state_q == IDLE || state_q == DONE)) begin
      dir_d = dir;
      mod_d = mod_val;
      os_d = oneshot;
      state_d = RUN;
    end else if (wrap && os_q)
      state_d = DONE;
    else if (state_q == LOAD)
      state_d = IDLE;
  end
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= IDLE;
      dir_q <= 1'b0;
      mod_q <= '0;
      os_q <= 1'b0;
      din_q <= '0;
      tc_q <= 1'b0;
    end else begin
      state_q <= state_d;
      dir_q <= dir_d;
      mod_q <= mod_d;
      os_q <= os_d;
      din_q <= din_d;
      tc_q <= tc_d;
    end
  end
endmodule

// File: tb/tb_jk_cnt_ctrl.sv
// tb_jk_cnt_ctrl: randomized scoreboard bench for jk_cnt_ctrl with a JK bank model
module tb_jk_cnt_ctrl;
  localparam int W = 4;
  localparam int MI = 0, ML = 1, MR = 2, MD = 3;
  logic clk = 1'b0;
  logic clr = 1'b1, start = 1'b0, stop = 1'b0, load = 1'b0, dir = 1'b0, oneshot = 1'b0, oe = 1'b1;
  logic [W-1:0] din = '0, mod_val = '0, q = '0;
  logic [W-1:0] j, k, dout;
  logic busy, tc;
  int errors = 0, checks = 0;
  typedef struct {
    logic [W-1:0] q;
    logic tc;
    logic busy;
    logic [W-1:0] dout;
  } exp_t;
  exp_t sb[$];
  int mq = 0, mdin = 0, mmod = 0, mdir = 0, mos = 0, mode = MI;

  jk_cnt_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .clr(clr), .start(start), .stop(stop), .load(load), .din(din),
    .dir(dir), .mod_val(mod_val), .oneshot(oneshot), .oe(oe), .q(q),
    .j(j), .k(k), .dout(dout), .busy(busy), .tc(tc)
  );

  always #5 clk = ~clk;
  always @(posedge clk) q <= (j & ~q) | (~k & q);

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
    end
  endtask

  exp_t e;
  always @(posedge clk) begin
    #3;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check("q", q, e.q);
      check("tc", tc, e.tc);
      check("busy", busy, e.busy);
      check("dout", dout, e.dout);
    end
  end

  task automatic step(input bit ld, input bit sp, input bit st, input int d, input int dr,
                      input int mv, input int os, input bit en);
    int m, nq;
    bit wr;
    clr = 1'b0;
    load = ld;
    stop = sp;
    start = st;
    din = W'(d);
    dir = dr[0];
    mod_val = W'(mv);
    oneshot = os[0];
    oe = en;
    m = (mmod == 0) ? 16 : mmod;
    nq = mq;
    wr = 1'b0;
    if (mode == MR && mdir == 1) begin
      wr = (mq == m - 1) || (mq == 15);
      nq = wr ? 0 : mq + 1;
    end else if (mode == MR) begin
      wr = (mq == 0);
      nq = wr ? m - 1 : mq - 1;
    end else if (mode == ML)
      nq = mdin;
    if (ld) begin
      mdin = d;
      mode = ML;
    end else if (sp)
      mode = (mode == MD) ? MD : MI;
    else if (st && (mode == MI || mode == MD)) begin
      mdir = dr;
      mmod = mv;
      mos = os;
      mode = MR;
    end else if (wr && mos == 1)
      mode = MD;
    else if (mode == ML)
      mode = MI;
    mq = nq;
    sb.push_back('{W'(nq), wr, mode == MR, en ? W'(nq) : W'(0)});
    @(negedge clk);
  endtask

  task automatic idle(input int n, input bit en);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, en);
  endtask

  task automatic pulse_clr(input bit en);
    load = 1'b0;
    stop = 1'b0;
    start = 1'b0;
    oe = en;
    clr = 1'b1;
    #1;
    check("busy_async_clr", busy, 0);
    check("tc_async_clr", tc, 0);
    check("dout_gate", dout, en ? mq : 0);
    sb.push_back('{W'(0), 1'b0, 1'b0, W'(0)});
    @(negedge clk);
    clr = 1'b0;
    mode = MI;
    mq = 0;
    mdin = 0;
    mmod = 0;
    mdir = 0;
    mos = 0;
  endtask

  initial begin
    pulse_clr(1);
    step(0, 0, 1, 0, 1, 0, 0, 1);
    idle(18, 1);
    step(0, 1, 0, 0, 0, 0, 0, 1);
    step(1, 0, 0, 7, 0, 0, 0, 1);
    idle(2, 1);
    step(0, 0, 1, 0, 0, 10, 0, 1);
    idle(12, 1);
    step(0, 1, 0, 0, 0, 0, 0, 1);
    pulse_clr(1);
    step(0, 0, 1, 0, 1, 5, 1, 1);
    idle(8, 1);
    step(0, 0, 1, 0, 1, 0, 0, 1);
    idle(5, 1);
    step(1, 1, 0, 3, 0, 0, 0, 1);
    idle(4, 1);
    step(0, 0, 1, 0, 1, 0, 0, 1);
    idle(6, 1);
    pulse_clr(0);
    idle(2, 1);
    step(0, 0, 1, 0, 1, 1, 0, 1);
    idle(3, 1);
    step(0, 1, 1, 0, 0, 1, 0, 1);
    step(0, 0, 1, 0, 0, 1, 0, 1);
    idle(3, 1);
    for (int n = 0; n < 800; n++) begin
      if ($urandom_range(0, 99) == 0)
        pulse_clr(1'($urandom_range(0, 1)));
      else
        step($urandom_range(0, 19) == 0, $urandom_range(0, 19) == 0, $urandom_range(0, 4) == 0,
             int'($urandom_range(0, 15)), int'($urandom_range(0, 1)), int'($urandom_range(0, 15)),
             int'($urandom_range(0, 3) == 0), $urandom_range(0, 3) != 0);
    end
    repeat (3) @(negedge clk);
    check("scoreboard_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
